// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles 16-bit commands from pairs of UART bytes.
// The high byte arrives first and the low byte second.
// An inter-byte timeout discards a half-received command.
//
// Ports:
//   clk, rst_n    - clock and asynchronous active-low reset
//   rx_rdy        - byte-available flag from the UART receiver
//   rx_data       - received byte, valid while rx_rdy=1
//   clr_cmd_rdy   - consumer acknowledge that clears cmd_rdy
//   clr_rx_rdy    - clear strobe back to the receiver (combinational)
//   cmd           - last assembled command {high, low}
//   cmd_rdy       - high while a new cmd is available
//   tmo_err       - one-cycle pulse on inter-byte timeout
module uart_cmd_ctrl #(
   parameter logic [16:0] TMO_CYC = 17'd100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   input  logic        clr_cmd_rdy,
   output logic        clr_rx_rdy,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   output logic        tmo_err
);

   localparam int unsigned CNT_W = 17;
   localparam logic [0:0]  IDLE    = 1'b0;
   localparam logic [0:0]  WAIT_LO = 1'b1;

   logic [0:0]       state, state_nxt;
   logic [7:0]       hi_byte, hi_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [15:0]      cmd_nxt;
   logic             cmd_rdy_nxt;
   logic             tmo_nxt;
   logic             tmo_hit;

   // Every cycle with rx_rdy high is an accept; silenced while in reset.
   assign clr_rx_rdy = rx_rdy & rst_n;

   assign tmo_hit = (cnt == (TMO_CYC - CNT_W'(1)));

   // Next-state and next-output logic.
   always_comb begin
      state_nxt   = state;
      hi_nxt      = hi_byte;
      cnt_nxt     = '0;
      cmd_nxt     = cmd;
      tmo_nxt     = 1'b0;
      // Acknowledge clears first so that a same-cycle low-byte accept wins.
      cmd_rdy_nxt = clr_cmd_rdy ? 1'b0 : cmd_rdy;

      case (state)
         IDLE: begin
            if (rx_rdy) begin
               hi_nxt      = rx_data;
               cmd_rdy_nxt = 1'b0;
               state_nxt   = WAIT_LO;
            end
         end
         WAIT_LO: begin
            if (rx_rdy) begin
               // rx_rdy beats a coincident timeout.
               cmd_nxt     = {hi_byte, rx_data};
               cmd_rdy_nxt = 1'b1;
               state_nxt   = IDLE;
            end else if (tmo_hit) begin
               hi_nxt    = 8'h00;
               tmo_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         hi_byte <= 8'h00;
         cnt     <= '0;
         cmd     <= 16'h0000;
         cmd_rdy <= 1'b0;
         tmo_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         hi_byte <= hi_nxt;
         cnt     <= cnt_nxt;
         cmd     <= cmd_nxt;
         cmd_rdy <= cmd_rdy_nxt;
         tmo_err <= tmo_nxt;
      end
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed self-checking bench for uart_cmd_ctrl.
// Instance u_dut_def uses the default timeout for the long-gap command;
// instance u_dut uses TMO_CYC=100 for the timeout scenarios.
module tb_uart_cmd_ctrl;

   logic        clk;
   logic        rst_n;

   logic        rx_rdy_a, clr_cmd_rdy_a, clr_rx_rdy_a, cmd_rdy_a, tmo_err_a;
   logic [7:0]  rx_data_a;
   logic [15:0] cmd_a;

   logic        rx_rdy, clr_cmd_rdy, clr_rx_rdy, cmd_rdy, tmo_err;
   logic [7:0]  rx_data;
   logic [15:0] cmd;

   int n_tests;
   int n_fail;

   uart_cmd_ctrl u_dut_def (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_rdy      (rx_rdy_a),
      .rx_data     (rx_data_a),
      .clr_cmd_rdy (clr_cmd_rdy_a),
      .clr_rx_rdy  (clr_rx_rdy_a),
      .cmd         (cmd_a),
      .cmd_rdy     (cmd_rdy_a),
      .tmo_err     (tmo_err_a)
   );

   uart_cmd_ctrl #(.TMO_CYC(17'd100)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_rdy      (rx_rdy),
      .rx_data     (rx_data),
      .clr_cmd_rdy (clr_cmd_rdy),
      .clr_rx_rdy  (clr_rx_rdy),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .tmo_err     (tmo_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present one byte to u_dut for exactly one clock edge; returns at the
   // negedge after the accepting edge with rx_rdy low again.
   task automatic send_byte(input logic [7:0] b, input string tag);
      @(negedge clk);
      rx_rdy  = 1'b1;
      rx_data = b;
      #1 check({tag, "_clr"}, 32'(clr_rx_rdy), 32'd1);
      @(negedge clk);
      rx_rdy  = 1'b0;
      rx_data = 8'hxx;
      #1 check({tag, "_clr_off"}, 32'(clr_rx_rdy), 32'd0);
   endtask

   initial begin
      int n;
      int clr_cnt;
      n_tests       = 0;
      n_fail        = 0;
      rst_n         = 1'b1;
      rx_rdy        = 1'b0;
      rx_data       = 8'h00;
      clr_cmd_rdy   = 1'b0;
      rx_rdy_a      = 1'b0;
      rx_data_a     = 8'h00;
      clr_cmd_rdy_a = 1'b0;

      // Reset state, with rx_rdy high to confirm clr_rx_rdy is held low.
      #2 rst_n = 1'b0;
      rx_rdy = 1'b1;
      #10;
      check("rst_cmd",     32'(cmd),        32'h0000);
      check("rst_cmd_rdy", 32'(cmd_rdy),    32'd0);
      check("rst_tmo",     32'(tmo_err),    32'd0);
      check("rst_clr",     32'(clr_rx_rdy), 32'd0);
      rx_rdy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic command with a 2000-cycle gap on the default-timeout instance.
      rx_rdy_a  = 1'b1;
      rx_data_a = 8'hA5;
      #1 check("basic_clr_hi", 32'(clr_rx_rdy_a), 32'd1);
      @(negedge clk);
      rx_rdy_a = 1'b0;
      #1 check("basic_clr_hi_off", 32'(clr_rx_rdy_a), 32'd0);
      check("basic_cmd_partial", 32'(cmd_a), 32'h0000);
      repeat (2000) @(negedge clk);
      rx_rdy_a  = 1'b1;
      rx_data_a = 8'h3C;
      #1 check("basic_clr_lo", 32'(clr_rx_rdy_a), 32'd1);
      @(negedge clk);
      rx_rdy_a = 1'b0;
      #1 check("basic_cmd", 32'(cmd_a), 32'hA53C);
      check("basic_cmd_rdy", 32'(cmd_rdy_a), 32'd1);
      check("basic_tmo", 32'(tmo_err_a), 32'd0);

      // Timeout: prior cmd ABCD, then a lone high byte 12.
      send_byte(8'hAB, "pre_hi");
      send_byte(8'hCD, "pre_lo");
      check("pre_cmd", 32'(cmd), 32'hABCD);
      send_byte(8'h12, "tmo_hi");
      check("tmo_cmd_rdy_cleared", 32'(cmd_rdy), 32'd0);
      n = 0;
      while (!tmo_err && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("tmo_latency", 32'(n), 32'd100);
      check("tmo_cmd_hold", 32'(cmd), 32'hABCD);
      @(negedge clk);
      check("tmo_pulse_once", 32'(tmo_err), 32'd0);
      send_byte(8'h34, "post_tmo_hi");
      check("post_tmo_partial", 32'(cmd), 32'hABCD);
      send_byte(8'h56, "post_tmo_lo");
      check("post_tmo_cmd", 32'(cmd), 32'h3456);
      check("post_tmo_rdy", 32'(cmd_rdy), 32'd1);

      // Timeout tie: low byte arrives in the cycle the count reads 99.
      send_byte(8'h9A, "tie_hi");
      repeat (98) @(negedge clk);
      check("tie_no_early_tmo", 32'(tmo_err), 32'd0);
      send_byte(8'h77, "tie_lo");
      check("tie_tmo", 32'(tmo_err), 32'd0);
      check("tie_cmd", 32'(cmd), 32'h9A77);
      check("tie_rdy", 32'(cmd_rdy), 32'd1);
      repeat (3) @(negedge clk);
      check("tie_tmo_later", 32'(tmo_err), 32'd0);

      // Acknowledge held through the low-byte accept: set wins.
      @(negedge clk);
      clr_cmd_rdy = 1'b1;
      send_byte(8'h5E, "ack_hi");
      send_byte(8'h21, "ack_lo");
      check("ack_cmd", 32'(cmd), 32'h5E21);
      check("ack_set_wins", 32'(cmd_rdy), 32'd1);
      clr_cmd_rdy = 1'b0;
      @(negedge clk);
      check("ack_hold", 32'(cmd_rdy), 32'd1);
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      #1 check("ack_clear", 32'(cmd_rdy), 32'd0);

      // Reset in the middle of a command.
      send_byte(8'hFF, "rst_hi");
      rst_n  = 1'b0;
      rx_rdy = 1'b1;
      #1 check("midrst_cmd", 32'(cmd), 32'h0000);
      check("midrst_clr", 32'(clr_rx_rdy), 32'd0);
      rx_rdy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      send_byte(8'h01, "midrst_hi");
      send_byte(8'h02, "midrst_lo");
      check("midrst_cmd_after", 32'(cmd), 32'h0102);

      // Back-to-back bytes on consecutive cycles.
      clr_cnt = 0;
      @(negedge clk);
      rx_rdy  = 1'b1;
      rx_data = 8'h11;
      #1 clr_cnt += int'(clr_rx_rdy);
      @(negedge clk);
      rx_data = 8'h22;
      #1 clr_cnt += int'(clr_rx_rdy);
      @(negedge clk);
      rx_data = 8'h33;
      #1 clr_cnt += int'(clr_rx_rdy);
      check("b2b_cmd1", 32'(cmd), 32'h1122);
      check("b2b_rdy1", 32'(cmd_rdy), 32'd1);
      @(negedge clk);
      rx_data = 8'h44;
      #1 clr_cnt += int'(clr_rx_rdy);
      check("b2b_cmd1_hold", 32'(cmd), 32'h1122);
      @(negedge clk);
      rx_rdy = 1'b0;
      #1 clr_cnt += int'(clr_rx_rdy);
      check("b2b_clr_count", 32'(clr_cnt), 32'd4);
      check("b2b_cmd2", 32'(cmd), 32'h3344);
      check("b2b_rdy2", 32'(cmd_rdy), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
